// File: rtl/anomaly_episode_logger.sv
// anomaly_episode_logger: snoops detector result writes and merges runs of anomalous samples
// into episode records queued in a FWFT FIFO. Define ANOMALY_LOG_TSTAMP_EN to add evt_time stamps.
module anomaly_episode_logger #(
    parameter int N     = 32,
    parameter int DEPTH = 16,
    parameter int LW    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wren,
    input  logic [N-1:0]           address_w,
    input  logic [N-1:0]           prediction_i,
    input  logic                   flush,
    input  logic                   clear,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [N-1:0]           evt_addr,
    output logic [LW-1:0]          evt_len,
    output logic [N-1:0]           evt_pred,
`ifdef ANOMALY_LOG_TSTAMP_EN
    output logic [N-1:0]           evt_time,
`endif
    output logic [15:0]            evt_count,
    output logic [15:0]            drop_count,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, OPEN} state_t;
    state_t state, next_state;

    logic [N-1:0]  start_addr, last_addr, first_pred;
    logic [LW-1:0] len;
    logic          label, contiguous, len_sat;
    logic          emit, open_new, extend;
    logic          push, pop;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    logic [N-1:0]  mem_addr [DEPTH];
    logic [LW-1:0] mem_len  [DEPTH];
    logic [N-1:0]  mem_pred [DEPTH];

    assign label      = prediction_i[0];
    assign contiguous = (address_w == last_addr + 1'b1);
    assign len_sat    = &len;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (clear)
            next_state = IDLE;
        else if (state == IDLE) begin
            if (wren && label) next_state = OPEN;
        end else if ((wren && !label) || (!wren && flush))
            next_state = IDLE;
    end

    // A discontiguous or length-saturated anomaly closes the episode and reopens in one cycle.
    always_comb begin
        emit     = 1'b0;
        open_new = 1'b0;
        extend   = 1'b0;
        if (!clear) begin
            if (state == IDLE)
                open_new = wren && label;
            else if (wren) begin
                if (!label)
                    emit = 1'b1;
                else if (contiguous && !len_sat)
                    extend = 1'b1;
                else begin
                    emit     = 1'b1;
                    open_new = 1'b1;
                end
            end else
                emit = flush;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_addr <= '0;
            last_addr  <= '0;
            first_pred <= '0;
            len        <= '0;
        end else if (open_new) begin
            start_addr <= address_w;
            last_addr  <= address_w;
            first_pred <= {prediction_i[N-1:1], 1'b0};
            len        <= {{(LW-1){1'b0}}, 1'b1};
        end else if (extend) begin
            last_addr <= address_w;
            len       <= len + 1'b1;
        end
    end

    assign empty     = (count == '0);
    assign full      = (count == FULL_LEVEL);
    assign level     = count;
    assign evt_valid = !empty;
    assign pop       = evt_valid && evt_ready;
    assign push      = emit && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= start_addr;
            mem_len[wr_ptr]  <= len;
            mem_pred[wr_ptr] <= first_pred;
        end
    end

    // Head fields read as zero while empty so stale storage never leaks to the host.
    assign evt_addr = empty ? '0 : mem_addr[rd_ptr];
    assign evt_len  = empty ? '0 : mem_len[rd_ptr];
    assign evt_pred = empty ? '0 : mem_pred[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            evt_count  <= '0;
            drop_count <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            evt_count  <= '0;
            drop_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (push && evt_count != 16'hFFFF)
                evt_count <= evt_count + 16'd1;
            if (emit && !push && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end

`ifdef ANOMALY_LOG_TSTAMP_EN
    logic [N-1:0] cycle_cnt, open_time;
    logic [N-1:0] mem_time [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     cycle_cnt <= '0;
        else if (clear) cycle_cnt <= '0;
        else            cycle_cnt <= cycle_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        open_time <= '0;
        else if (open_new) open_time <= cycle_cnt;
    end

    always_ff @(posedge clk) begin
        if (push) mem_time[wr_ptr] <= open_time;
    end

    assign evt_time = empty ? '0 : mem_time[rd_ptr];
`endif

endmodule

// File: tb/tb_anomaly_episode_logger.sv
// tb_anomaly_episode_logger: table-driven vectors plus a scoreboard that checks every popped
// episode record against the records the stimulus was expected to close.
module tb_anomaly_episode_logger;
    logic        clk, reset, wren, flush, clear, evt_ready;
    logic [31:0] address_w, prediction_i;
    logic        evt_valid, full, empty;
    logic [31:0] evt_addr, evt_pred;
    logic [15:0] evt_len, evt_count, drop_count;
    logic [4:0]  level;
`ifdef ANOMALY_LOG_TSTAMP_EN
    logic [31:0] evt_time;
`endif

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] len;
        logic [31:0] pred;
    } rec_t;
    rec_t sbq[$];

    typedef struct {
        logic        wren;
        logic [31:0] addr;
        logic [31:0] pred;
        logic        flush;
        logic        exp_valid;
        int          exp_level;
        int          exp_count;
        logic        push_rec;
        rec_t        rec;
    } vec_t;
    vec_t vecs[14];

    anomaly_episode_logger dut (
        .clk(clk), .reset(reset), .wren(wren), .address_w(address_w),
        .prediction_i(prediction_i), .flush(flush), .clear(clear),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_addr(evt_addr),
        .evt_len(evt_len), .evt_pred(evt_pred),
`ifdef ANOMALY_LOG_TSTAMP_EN
        .evt_time(evt_time),
`endif
        .evt_count(evt_count), .drop_count(drop_count), .level(level),
        .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] p, input logic f);
        wren = w;
        address_w = a;
        prediction_i = p;
        flush = f;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
        clear = 1'b0;
        sbq.delete();
    endtask

    function automatic vec_t mkv(input logic w, input logic [31:0] a, input logic [31:0] p, input logic f,
                                 input logic ev, input int el, input int ec,
                                 input logic pr, input logic [31:0] ra, input logic [15:0] rl, input logic [31:0] rp);
        vec_t v;
        v.wren = w; v.addr = a; v.pred = p; v.flush = f;
        v.exp_valid = ev; v.exp_level = el; v.exp_count = ec;
        v.push_rec = pr; v.rec = '{addr: ra, len: rl, pred: rp};
        return v;
    endfunction

    // Records are compared on the cycle they are popped, while the head is still presented.
    always @(negedge clk) begin
        rec_t r;
        if (reset && !clear && evt_valid && evt_ready) begin
            if (sbq.size() == 0)
                checkOutput("sb_unexpected_pop", 64'd1, 64'd0);
            else begin
                r = sbq.pop_front();
                checkOutput("sb_addr", evt_addr, r.addr);
                checkOutput("sb_len",  evt_len,  r.len);
                checkOutput("sb_pred", evt_pred, r.pred);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b0; wren = 1'b0; flush = 1'b0; clear = 1'b0; evt_ready = 1'b0;
        address_w = '0; prediction_i = '0;

        vecs[0]  = mkv(1, 32'd10,         32'hABCD0001, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mkv(1, 32'd11,         32'h00000003, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mkv(1, 32'd12,         32'h00000005, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mkv(1, 32'd13,         32'h00000000, 0, 1, 1, 1, 1, 32'd10, 16'd3, 32'hABCD0000);
        vecs[4]  = mkv(0, 32'd0,          32'h00000000, 0, 1, 1, 1, 0, 0, 0, 0);
        vecs[5]  = mkv(1, 32'd5,          32'h00000505, 0, 1, 1, 1, 0, 0, 0, 0);
        vecs[6]  = mkv(1, 32'd6,          32'h00000607, 0, 1, 1, 1, 0, 0, 0, 0);
        vecs[7]  = mkv(1, 32'd9,          32'h00000909, 0, 1, 2, 2, 1, 32'd5, 16'd2, 32'h00000504);
        vecs[8]  = mkv(0, 32'd0,          32'h00000000, 1, 1, 3, 3, 1, 32'd9, 16'd1, 32'h00000908);
        vecs[9]  = mkv(0, 32'd0,          32'h00000000, 1, 1, 3, 3, 0, 0, 0, 0);
        vecs[10] = mkv(1, 32'd20,         32'h00000000, 0, 1, 3, 3, 0, 0, 0, 0);
        vecs[11] = mkv(1, 32'hFFFFFFFF,   32'h00000011, 0, 1, 3, 3, 0, 0, 0, 0);
        vecs[12] = mkv(1, 32'h00000000,   32'h00000023, 0, 1, 3, 3, 0, 0, 0, 0);
        vecs[13] = mkv(1, 32'h00000001,   32'h00000000, 0, 1, 4, 4, 1, 32'hFFFFFFFF, 16'd2, 32'h00000010);

        #12;
        checkOutput("rst_valid", evt_valid, 0);
        checkOutput("rst_addr", evt_addr, 0);
        checkOutput("rst_len", evt_len, 0);
        checkOutput("rst_pred", evt_pred, 0);
        checkOutput("rst_evt_count", evt_count, 0);
        checkOutput("rst_drop_count", drop_count, 0);
        checkOutput("rst_level", level, 0);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_empty", empty, 1);
        @(posedge clk);
        #1 reset = 1'b1;

`ifdef ANOMALY_LOG_TSTAMP_EN
        repeat (7) applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 32'd50, 32'h51, 0);
        applyStimulus(1, 32'd51, 32'h0, 0);
        checkOutput("ts_valid", evt_valid, 1);
        checkOutput("ts_time", evt_time, 7);
`endif
        do_clear();
        checkOutput("clr0_level", level, 0);
        checkOutput("clr0_count", evt_count, 0);

        // Table: merge, discontiguity, flush, address wrap; head stays on the first record.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].wren, vecs[i].addr, vecs[i].pred, vecs[i].flush);
            if (vecs[i].push_rec) sbq.push_back(vecs[i].rec);
            checkOutput($sformatf("v%0d_valid", i), evt_valid, vecs[i].exp_valid);
            checkOutput($sformatf("v%0d_level", i), level, vecs[i].exp_level);
            checkOutput($sformatf("v%0d_count", i), evt_count, vecs[i].exp_count);
            if (vecs[i].exp_valid) begin
                checkOutput($sformatf("v%0d_head_addr", i), evt_addr, 10);
                checkOutput($sformatf("v%0d_head_len", i), evt_len, 3);
            end
        end

        evt_ready = 1'b1;
        for (int k = 0; k < 20 && !empty; k++) applyStimulus(0, 0, 0, 0);
        evt_ready = 1'b0;
        checkOutput("drain_empty", empty, 1);
        checkOutput("drain_sb_left", sbq.size(), 0);

        // Overflow: 17 isolated anomalies into a 16-deep FIFO.
        do_clear();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1, 32'(200 + 2*i), 32'((200 + 2*i) * 16 + 1), 0);
            applyStimulus(1, 32'(201 + 2*i), 32'd0, 0);
            if (i < 16) sbq.push_back('{addr: 32'(200 + 2*i), len: 16'd1, pred: 32'((200 + 2*i) * 16)});
        end
        checkOutput("ovf_level", level, 16);
        checkOutput("ovf_full", full, 1);
        checkOutput("ovf_drop", drop_count, 1);
        checkOutput("ovf_count", evt_count, 16);
        checkOutput("ovf_head_addr", evt_addr, 200);
        checkOutput("ovf_head_len", evt_len, 1);
        checkOutput("ovf_head_pred", evt_pred, 200 * 16);

        applyStimulus(1, 32'd300, 32'd300 * 16 + 1, 0);
        evt_ready = 1'b1;
        applyStimulus(1, 32'd301, 32'd0, 0);
        evt_ready = 1'b0;
        sbq.push_back('{addr: 32'd300, len: 16'd1, pred: 32'd300 * 16});
        checkOutput("pp_level", level, 16);
        checkOutput("pp_drop", drop_count, 1);
        checkOutput("pp_count", evt_count, 17);
        checkOutput("pp_head_addr", evt_addr, 202);

        // Clear with an open episode: nothing may be emitted afterwards.
        applyStimulus(1, 32'd400, 32'd400 * 16 + 1, 0);
        do_clear();
        checkOutput("clr_level", level, 0);
        checkOutput("clr_empty", empty, 1);
        checkOutput("clr_valid", evt_valid, 0);
        checkOutput("clr_count", evt_count, 0);
        checkOutput("clr_drop", drop_count, 0);
        applyStimulus(1, 32'd401, 32'd0, 0);
        checkOutput("clr_no_emit", level, 0);

        // Asynchronous reset mid-episode with a record already queued.
        applyStimulus(1, 32'd40, 32'h41, 0);
        applyStimulus(1, 32'd41, 32'h0, 0);
        applyStimulus(1, 32'd60, 32'h61, 0);
        applyStimulus(1, 32'd61, 32'h63, 0);
        checkOutput("pre_rst_level", level, 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("mid_rst_valid", evt_valid, 0);
        checkOutput("mid_rst_addr", evt_addr, 0);
        checkOutput("mid_rst_len", evt_len, 0);
        checkOutput("mid_rst_count", evt_count, 0);
        checkOutput("mid_rst_level", level, 0);
        checkOutput("mid_rst_empty", empty, 1);
        sbq.delete();
        @(posedge clk);
        #1 reset = 1'b1;
        applyStimulus(1, 32'd62, 32'd0, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("post_rst_level", level, 0);
        checkOutput("post_rst_valid", evt_valid, 0);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
